// File: rtl/e603_exu_nice_issue.sv
// e603_exu_nice_issue: NICE decode, hazard-gated issue and in-order retire; E603_CFG_NICE_PAIR_EN enables two-beat pair ops
module e603_exu_nice_issue #(
  parameter int NICE_OUTS_DEPTH = 4,
  parameter int RF_IDX_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  output logic                i_ready,
  input  logic [31:0]         i_instr,
  input  logic [31:0]         i_rs1,
  input  logic [31:0]         i_rs2,
  output logic                dec_rs1_en,
  output logic                dec_rs2_en,
  output logic                dec_rd_en,
  output logic                dec_rd_mac,
  output logic                dec_pair,
  output logic                dec_ilgl,
  output logic                o_ilgl,
  output logic                nice_req_valid,
  input  logic                nice_req_ready,
  output logic [31:0]         nice_req_instr,
  output logic [31:0]         nice_req_rs1,
  output logic [31:0]         nice_req_rs2,
  input  logic                nice_rsp_valid,
  output logic                nice_rsp_ready,
  input  logic [31:0]         nice_rsp_rdat,
  input  logic                nice_rsp_err,
  output logic                o_wbck_valid,
  input  logic                o_wbck_ready,
  output logic [RF_IDX_W-1:0] o_wbck_idx,
  output logic [31:0]         o_wbck_wdat,
  output logic                o_wbck_err,
  output logic                o_nice_busy
);
  localparam int PW = $clog2(NICE_OUTS_DEPTH);
  logic [NICE_OUTS_DEPTH-1:0] vld, e_rd_en, e_pair;
  logic [RF_IDX_W-1:0] e_idx [NICE_OUTS_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [RF_IDX_W-1:0] rd_idx, rd_hi, rs1_idx, rs2_idx;
  logic full, empty, hazard, push, pop, rsp_hs, h_rd, h_pair, beat, opc_ok;
  function automatic logic hit(input logic [RF_IDX_W-1:0] e, input logic ep, input logic [RF_IDX_W-1:0] q);
    return (q != '0) && ((q == e) || (ep && (q[RF_IDX_W-1:1] == e[RF_IDX_W-1:1])));
  endfunction
  assign rd_idx = RF_IDX_W'(i_instr[11:7]);
  assign rd_hi = rd_idx | RF_IDX_W'(1);
  assign rs1_idx = RF_IDX_W'(i_instr[19:15]);
  assign rs2_idx = RF_IDX_W'(i_instr[24:20]);
  assign dec_rd_en = i_instr[14];
  assign dec_rs1_en = i_instr[13];
  assign dec_rs2_en = i_instr[12];
  assign dec_rd_mac = i_instr[31];
  assign opc_ok = (i_instr[6:0] == 7'b0001011) | (i_instr[6:0] == 7'b0101011) |
                  (i_instr[6:0] == 7'b1011011) | (i_instr[6:0] == 7'b1111011);
  assign dec_ilgl = !opc_ok | (dec_pair & i_instr[7]);
  assign full = vld[wptr];
  assign empty = !vld[rptr];
  assign o_nice_busy = !empty;
  // conservative hazard scan over every registered entry, including one retiring this cycle
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NICE_OUTS_DEPTH; i++)
      hazard |= vld[i] & e_rd_en[i] &
                ((dec_rs1_en & hit(e_idx[i], e_pair[i], rs1_idx)) |
                 (dec_rs2_en & hit(e_idx[i], e_pair[i], rs2_idx)) |
                 (dec_rd_en & (hit(e_idx[i], e_pair[i], rd_idx) | (dec_pair & hit(e_idx[i], e_pair[i], rd_hi)))));
  end
  assign nice_req_valid = i_valid & !dec_ilgl & !full & !hazard;
  assign o_ilgl = i_valid & dec_ilgl;
  assign i_ready = o_ilgl | (nice_req_valid & nice_req_ready);
  assign push = nice_req_valid & nice_req_ready;
  assign nice_req_instr = i_instr;
  assign nice_req_rs1 = i_rs1;
  assign nice_req_rs2 = i_rs2;
  assign h_rd = e_rd_en[rptr];
  assign h_pair = h_rd & e_pair[rptr];
  assign nice_rsp_ready = !empty & (h_rd ? o_wbck_ready : 1'b1);
  assign o_wbck_valid = !empty & h_rd & nice_rsp_valid;
  assign o_wbck_idx = e_idx[rptr] | RF_IDX_W'(beat);
  assign o_wbck_wdat = nice_rsp_rdat;
  assign o_wbck_err = nice_rsp_err;
  assign rsp_hs = nice_rsp_valid & nice_rsp_ready;
  assign pop = rsp_hs & (!h_pair | beat);
`ifdef E603_CFG_NICE_PAIR_EN
  assign dec_pair = i_instr[30];
  // pair results retire low register first, then the odd partner
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) beat <= 1'b0;
    else if (rsp_hs & h_pair) beat <= !beat;
`else
  assign dec_pair = 1'b0;
  assign beat = 1'b0;
`endif
  // occupancy and pointers; slot-valid bits make full/empty a single lookup
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        vld[wptr] <= 1'b1;
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        vld[rptr] <= 1'b0;
        rptr <= rptr + PW'(1);
      end
    end
  // entry payload needs no reset, it is qualified by vld
  always_ff @(posedge clk)
    if (push) begin
      e_rd_en[wptr] <= dec_rd_en;
      e_pair[wptr] <= dec_pair;
      e_idx[wptr] <= rd_idx;
    end
endmodule

// File: tb/tb_e603_exu_nice_issue.sv
// tb_e603_exu_nice_issue: random traffic checked against a queue-based model of issue and retire
module tb_e603_exu_nice_issue;
  localparam int DEPTH = 4;
`ifdef E603_CFG_NICE_PAIR_EN
  localparam bit PAIR = 1'b1;
`else
  localparam bit PAIR = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_valid = 1'b0, i_ready;
  logic [31:0] i_instr = '0, i_rs1 = '0, i_rs2 = '0;
  logic dec_rs1_en, dec_rs2_en, dec_rd_en, dec_rd_mac, dec_pair, dec_ilgl, o_ilgl;
  logic nice_req_valid, nice_req_ready = 1'b0;
  logic [31:0] nice_req_instr, nice_req_rs1, nice_req_rs2;
  logic nice_rsp_valid = 1'b0, nice_rsp_ready, nice_rsp_err = 1'b0;
  logic [31:0] nice_rsp_rdat = '0;
  logic o_wbck_valid, o_wbck_ready = 1'b0, o_wbck_err, o_nice_busy;
  logic [4:0] o_wbck_idx;
  logic [31:0] o_wbck_wdat;
  int checks = 0, errors = 0;
  typedef struct {bit rd_en; int rd; bit pair;} ent_t;
  ent_t mq[$];
  int mbeat = 0;
  logic [6:0] legal_ops [4] = '{7'b0001011, 7'b0101011, 7'b1011011, 7'b1111011};

  e603_exu_nice_issue #(.NICE_OUTS_DEPTH(DEPTH), .RF_IDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i_instr(i_instr),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .dec_rs1_en(dec_rs1_en), .dec_rs2_en(dec_rs2_en),
    .dec_rd_en(dec_rd_en), .dec_rd_mac(dec_rd_mac), .dec_pair(dec_pair), .dec_ilgl(dec_ilgl),
    .o_ilgl(o_ilgl), .nice_req_valid(nice_req_valid), .nice_req_ready(nice_req_ready),
    .nice_req_instr(nice_req_instr), .nice_req_rs1(nice_req_rs1), .nice_req_rs2(nice_req_rs2),
    .nice_rsp_valid(nice_rsp_valid), .nice_rsp_ready(nice_rsp_ready), .nice_rsp_rdat(nice_rsp_rdat),
    .nice_rsp_err(nice_rsp_err), .o_wbck_valid(o_wbck_valid), .o_wbck_ready(o_wbck_ready),
    .o_wbck_idx(o_wbck_idx), .o_wbck_wdat(o_wbck_wdat), .o_wbck_err(o_wbck_err),
    .o_nice_busy(o_nice_busy));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic bit writes(input ent_t e, input int r);
    return e.rd_en && r != 0 && (r == e.rd || (e.pair && r == e.rd + 1));
  endfunction

  initial begin
    bit ilgl, pair, haz, req_v, rdy, hs, exp_rspr, exp_wbv;
    int rd, rs1, rs2;
    logic [6:0] op;
    #1;
    check("rst_busy", 32'(o_nice_busy), 0);
    check("rst_wbv", 32'(o_wbck_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 3)];
      i_instr = $urandom;
      i_instr[6:0] = op;
      i_instr[11:7] = 5'($urandom_range(0, 7));
      i_instr[19:15] = 5'($urandom_range(0, 7));
      i_instr[24:20] = 5'($urandom_range(0, 7));
      i_rs1 = $urandom;
      i_rs2 = $urandom;
      i_valid = $urandom_range(0, 3) != 0;
      nice_req_ready = $urandom_range(0, 9) < 7;
      nice_rsp_valid = $urandom_range(0, 1);
      nice_rsp_rdat = $urandom;
      nice_rsp_err = $urandom_range(0, 7) == 0;
      o_wbck_ready = $urandom_range(0, 9) < 6;
      if (cyc % 700 == 350) begin
        rst_n = 1'b0;
        i_valid = 1'b0;
        nice_rsp_valid = 1'b1;
        #1;
        check("arst_busy", 32'(o_nice_busy), 0);
        check("arst_wbv", 32'(o_wbck_valid), 0);
        check("arst_rspr", 32'(nice_rsp_ready), 0);
        mq.delete();
        mbeat = 0;
        nice_rsp_valid = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        continue;
      end
      #1;
      rd = int'(i_instr[11:7]);
      rs1 = int'(i_instr[19:15]);
      rs2 = int'(i_instr[24:20]);
      pair = PAIR && i_instr[30];
      ilgl = !(op inside {7'b0001011, 7'b0101011, 7'b1011011, 7'b1111011}) || (pair && rd % 2 == 1);
      haz = 0;
      foreach (mq[k])
        haz |= (i_instr[13] && writes(mq[k], rs1)) || (i_instr[12] && writes(mq[k], rs2)) ||
               (i_instr[14] && (writes(mq[k], rd) || (pair && writes(mq[k], rd + 1))));
      req_v = i_valid && !ilgl && mq.size() < DEPTH && !haz;
      rdy = (i_valid && ilgl) || (req_v && nice_req_ready);
      exp_rspr = mq.size() != 0 && (mq[0].rd_en ? o_wbck_ready : 1'b1);
      exp_wbv = mq.size() != 0 && mq[0].rd_en && nice_rsp_valid;
      check("dec_rd_en", 32'(dec_rd_en), 32'(i_instr[14]));
      check("dec_rs1_en", 32'(dec_rs1_en), 32'(i_instr[13]));
      check("dec_rs2_en", 32'(dec_rs2_en), 32'(i_instr[12]));
      check("dec_rd_mac", 32'(dec_rd_mac), 32'(i_instr[31]));
      check("dec_pair", 32'(dec_pair), 32'(pair));
      check("dec_ilgl", 32'(dec_ilgl), 32'(ilgl));
      check("o_ilgl", 32'(o_ilgl), 32'(i_valid && ilgl));
      check("req_valid", 32'(nice_req_valid), 32'(req_v));
      check("i_ready", 32'(i_ready), 32'(rdy));
      check("req_instr", nice_req_instr, i_instr);
      check("req_rs1", nice_req_rs1, i_rs1);
      check("req_rs2", nice_req_rs2, i_rs2);
      check("busy", 32'(o_nice_busy), 32'(mq.size() != 0));
      check("rsp_ready", 32'(nice_rsp_ready), 32'(exp_rspr));
      check("wbck_valid", 32'(o_wbck_valid), 32'(exp_wbv));
      if (exp_wbv) begin
        check("wbck_idx", 32'(o_wbck_idx), 32'(mq[0].rd + mbeat));
        check("wbck_wdat", o_wbck_wdat, nice_rsp_rdat);
        check("wbck_err", 32'(o_wbck_err), 32'(nice_rsp_err));
      end
      hs = nice_rsp_valid && exp_rspr;
      @(posedge clk);
      if (hs) begin
        if (mq[0].rd_en && mq[0].pair && mbeat == 0) mbeat = 1;
        else begin
          void'(mq.pop_front());
          mbeat = 0;
        end
      end
      if (req_v && nice_req_ready) mq.push_back('{rd_en: i_instr[14], rd: rd, pair: pair});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
